// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
package wb_commit_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned EXCEP_W = 4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [1:0]  PRIV_M      = 2'b11;

  typedef struct packed {
    logic regwrite;
    logic csrwrite;
  } control_t;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [EXCEP_W-1:0] excep;
    logic [1:0]         priviledgeMode;
    logic [4:0]         dst;
    logic [XLEN-1:0]    writedata;
    logic [11:0]        csraddr;
    logic [XLEN-1:0]    csrdata;
    control_t           ctl;
  } writeback_data_t;

  typedef enum logic [2:0] {
    RUN,
    T_EPC,
    T_CAUSE,
    T_STATUS,
    T_REDIR
  } commit_state_t;

  // mstatus on trap entry: MPP <- prior privilege, MPIE <- MIE, MIE <- 0.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] old,
                                                   input logic [1:0]      mpp);
    logic [XLEN-1:0] r;
    r        = old;
    r[12:11] = mpp;
    r[7]     = old[3];
    r[3]     = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/wb_commit_trap.sv
// Trap sequencer: latches the excepting instruction and walks mepc/mcause/mstatus/redirect.
module trap_seq
  import wb_commit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               take,
  input  logic [XLEN-1:0]    pc,
  input  logic [EXCEP_W-1:0] excep,
  input  logic [1:0]         priv,
  input  logic [XLEN-1:0]    csrdata,
  input  logic [XLEN-1:0]    mtvec,
  output commit_state_t      state,
  output logic               csr_wen,
  output logic [11:0]        csr_wa,
  output logic [XLEN-1:0]    csr_wd,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc
);

  commit_state_t      state_q, state_d;
  logic [XLEN-1:0]    pc_q;
  logic [EXCEP_W-1:0] excep_q;
  logic [1:0]         priv_q;
  logic [XLEN-1:0]    csrdata_q;

  logic unused_mtvec;
  assign unused_mtvec = ^mtvec[1:0];

  // State register and exception latches; latches load only when a trap is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      excep_q   <= '0;
      priv_q    <= '0;
      csrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && take) begin
        pc_q      <= pc;
        excep_q   <= excep;
        priv_q    <= priv;
        csrdata_q <= csrdata;
      end
    end
  end

  // Next state and per-state CSR write / redirect; outputs muted while reset is held.
  always_comb begin
    state_d        = state_q;
    csr_wen        = 1'b0;
    csr_wa         = '0;
    csr_wd         = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      RUN: if (take) state_d = T_EPC;
      T_EPC: begin
        csr_wen = !reset;
        csr_wa  = CSR_MEPC;
        csr_wd  = pc_q;
        state_d = T_CAUSE;
      end
      T_CAUSE: begin
        csr_wen = !reset;
        csr_wa  = CSR_MCAUSE;
        csr_wd  = {{(XLEN-EXCEP_W){1'b0}}, excep_q};
        state_d = T_STATUS;
      end
      T_STATUS: begin
        csr_wen = !reset;
        csr_wa  = CSR_MSTATUS;
        csr_wd  = trap_mstatus(csrdata_q, priv_q);
        state_d = T_REDIR;
      end
      T_REDIR: begin
        redirect_valid = !reset;
        redirect_pc    = reset ? '0 : {mtvec[XLEN-1:2], 2'b00};
        state_d        = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/wb_commit.sv
// Commit stage: retires writeback results to GPR/CSR files and sequences traps.
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  writeback_data_t  dataW,
  input  logic [XLEN-1:0]  mtvec,
  output logic             rf_wen,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             csr_wen,
  output logic [11:0]      csr_wa,
  output logic [XLEN-1:0]  csr_wd,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             stall,
  output logic [1:0]       priv_mode,
  output logic [XLEN-1:0]  minstret
);

  commit_state_t   state;
  logic            commit, take;
  logic            trap_csr_wen;
  logic [11:0]     trap_csr_wa;
  logic [XLEN-1:0] trap_csr_wd;
  logic [XLEN-1:0] minstret_q;
  logic [1:0]      priv_mode_q;

  assign commit = !reset && state == RUN && dataW.valid && dataW.excep == '0;
  assign take   = state == RUN && dataW.valid && dataW.excep != '0;

  trap_seq u_trap_seq (
    .clk            (clk),
    .reset          (reset),
    .take           (take),
    .pc             (dataW.pc),
    .excep          (dataW.excep),
    .priv           (dataW.priviledgeMode),
    .csrdata        (dataW.csrdata),
    .mtvec          (mtvec),
    .state          (state),
    .csr_wen        (trap_csr_wen),
    .csr_wa         (trap_csr_wa),
    .csr_wd         (trap_csr_wd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Retired count and privilege; trap exit (leaving T_REDIR) enters M-mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      minstret_q  <= '0;
      priv_mode_q <= PRIV_M;
    end else if (commit) begin
      minstret_q  <= minstret_q + 64'd1;
      priv_mode_q <= dataW.priviledgeMode;
    end else if (state == T_REDIR) begin
      priv_mode_q <= PRIV_M;
    end
  end

  // Write-port mux: commits own the ports in RUN, the trap sequencer elsewhere.
  always_comb begin
    rf_wen  = commit && dataW.ctl.regwrite && dataW.dst != 5'd0;
    rf_wa   = rf_wen ? dataW.dst : '0;
    rf_wd   = rf_wen ? dataW.writedata : '0;
    csr_wen = trap_csr_wen;
    csr_wa  = trap_csr_wa;
    csr_wd  = trap_csr_wd;
    if (state == RUN) begin
      csr_wen = commit && dataW.ctl.csrwrite;
      csr_wa  = csr_wen ? dataW.csraddr : '0;
      csr_wd  = csr_wen ? dataW.csrdata : '0;
    end
    stall = !reset && (take || state != RUN);
  end

  assign minstret  = minstret_q;
  assign priv_mode = priv_mode_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed, table-driven bench for wb_commit plus trap, mid-trap reset and wrap sequences.
module tb_wb_commit;
  import wb_commit_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  writeback_data_t dataW;
  logic [63:0]     mtvec;
  logic            rf_wen, csr_wen, redirect_valid, stall;
  logic [4:0]      rf_wa;
  logic [11:0]     csr_wa;
  logic [63:0]     rf_wd, csr_wd, redirect_pc, minstret;
  logic [1:0]      priv_mode;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_minstret = 64'd0;

  wb_commit dut (
    .clk            (clk),
    .reset          (reset),
    .dataW          (dataW),
    .mtvec          (mtvec),
    .rf_wen         (rf_wen),
    .rf_wa          (rf_wa),
    .rf_wd          (rf_wd),
    .csr_wen        (csr_wen),
    .csr_wa         (csr_wa),
    .csr_wd         (csr_wd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .priv_mode      (priv_mode),
    .minstret       (minstret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  dst;
    logic        rw;
    logic        cw;
    logic [11:0] ca;
    logic [63:0] cd;
    logic [63:0] wd;
    logic [1:0]  priv;
    logic        e_rf_wen;
    logic [4:0]  e_rf_wa;
    logic [63:0] e_rf_wd;
    logic        e_csr_wen;
    logic [11:0] e_csr_wa;
    logic [63:0] e_csr_wd;
    logic        e_inc;
    logic [1:0]  e_priv;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ex, input logic [63:0] pc,
                       input logic [4:0] dst, input logic rw, input logic cw,
                       input logic [11:0] ca, input logic [63:0] cd, input logic [63:0] wd,
                       input logic [1:0] priv);
    dataW.valid          = v;
    dataW.excep          = ex;
    dataW.pc             = pc;
    dataW.dst            = dst;
    dataW.ctl.regwrite   = rw;
    dataW.ctl.csrwrite   = cw;
    dataW.csraddr        = ca;
    dataW.csrdata        = cd;
    dataW.writedata      = wd;
    dataW.priviledgeMode = priv;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 64'd0, 5'd0, 1'b0, 1'b0, 12'd0, 64'd0, 64'd0, 2'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mtvec = 64'h8000_0101;
    idle();
    tick();
    tick();
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_rf_wen", {63'd0, rf_wen}, 64'd0);
    check("reset_csr_wen", {63'd0, csr_wen}, 64'd0);
    reset = 1'b0;
    #1;
    check("reset_minstret", minstret, 64'd0);
    check("reset_priv", {62'd0, priv_mode}, 64'd3);
    check("reset_redirect", {63'd0, redirect_valid}, 64'd0);
    check("reset_redirect_pc", redirect_pc, 64'd0);

    // valid dst rw cw ca cd wd priv | rf_wen wa wd csr_wen wa wd inc priv
    vecs[0] = '{1'b1, 5'd5, 1'b1, 1'b0, 12'h000, 64'h0, 64'h1234, 2'd3,
                1'b1, 5'd5, 64'h1234, 1'b0, 12'h000, 64'h0, 1'b1, 2'd3};
    vecs[1] = '{1'b1, 5'd0, 1'b1, 1'b0, 12'h000, 64'h0, 64'h55, 2'd0,
                1'b0, 5'd0, 64'h0, 1'b0, 12'h000, 64'h0, 1'b1, 2'd0};
    vecs[2] = '{1'b1, 5'd3, 1'b1, 1'b1, 12'h305, 64'h8000_0000, 64'h7, 2'd1,
                1'b1, 5'd3, 64'h7, 1'b1, 12'h305, 64'h8000_0000, 1'b1, 2'd1};
    vecs[3] = '{1'b0, 5'd7, 1'b1, 1'b1, 12'h340, 64'hAA, 64'hBB, 2'd3,
                1'b0, 5'd0, 64'h0, 1'b0, 12'h000, 64'h0, 1'b0, 2'd1};
    vecs[4] = '{1'b1, 5'd9, 1'b0, 1'b0, 12'h340, 64'hAA, 64'hBB, 2'd3,
                1'b0, 5'd0, 64'h0, 1'b0, 12'h000, 64'h0, 1'b1, 2'd3};

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].valid, 4'd0, 64'h100 + 64'(i), vecs[i].dst, vecs[i].rw, vecs[i].cw,
            vecs[i].ca, vecs[i].cd, vecs[i].wd, vecs[i].priv);
      #2;
      check($sformatf("v%0d_rf_wen", i), {63'd0, rf_wen}, {63'd0, vecs[i].e_rf_wen});
      check($sformatf("v%0d_rf_wa", i), {59'd0, rf_wa}, {59'd0, vecs[i].e_rf_wa});
      check($sformatf("v%0d_rf_wd", i), rf_wd, vecs[i].e_rf_wd);
      check($sformatf("v%0d_csr_wen", i), {63'd0, csr_wen}, {63'd0, vecs[i].e_csr_wen});
      check($sformatf("v%0d_csr_wa", i), {52'd0, csr_wa}, {52'd0, vecs[i].e_csr_wa});
      check($sformatf("v%0d_csr_wd", i), csr_wd, vecs[i].e_csr_wd);
      check($sformatf("v%0d_stall", i), {63'd0, stall}, 64'd0);
      if (vecs[i].e_inc) exp_minstret = exp_minstret + 64'd1;
      tick();
      check($sformatf("v%0d_minstret", i), minstret, exp_minstret);
      check($sformatf("v%0d_priv", i), {62'd0, priv_mode}, {62'd0, vecs[i].e_priv});
    end

    // Drop to U-mode so the trap's switch to M is observable.
    drive(1'b1, 4'd0, 64'h200, 5'd0, 1'b0, 1'b0, 12'd0, 64'd0, 64'd0, 2'd0);
    exp_minstret = exp_minstret + 64'd1;
    tick();
    check("pre_trap_priv", {62'd0, priv_mode}, 64'd0);

    // Exception: held by upstream for the whole sequence; MIE=1 in csrdata.
    drive(1'b1, 4'd2, 64'h8000_0010, 5'd4, 1'b1, 1'b1, 12'h305, 64'h8, 64'h99, 2'd0);
    #1;
    check("exc_stall", {63'd0, stall}, 64'd1);
    check("exc_rf_wen", {63'd0, rf_wen}, 64'd0);
    check("exc_csr_wen", {63'd0, csr_wen}, 64'd0);
    tick();
    check("epc_wen", {63'd0, csr_wen}, 64'd1);
    check("epc_wa", {52'd0, csr_wa}, 64'h341);
    check("epc_wd", csr_wd, 64'h8000_0010);
    check("epc_stall", {63'd0, stall}, 64'd1);
    check("epc_rf_wen", {63'd0, rf_wen}, 64'd0);
    tick();
    check("cause_wen", {63'd0, csr_wen}, 64'd1);
    check("cause_wa", {52'd0, csr_wa}, 64'h342);
    check("cause_wd", csr_wd, 64'd2);
    check("cause_stall", {63'd0, stall}, 64'd1);
    tick();
    check("status_wen", {63'd0, csr_wen}, 64'd1);
    check("status_wa", {52'd0, csr_wa}, 64'h300);
    check("status_wd", csr_wd, 64'h80);
    check("status_stall", {63'd0, stall}, 64'd1);
    check("status_redir", {63'd0, redirect_valid}, 64'd0);
    tick();
    check("redir_valid", {63'd0, redirect_valid}, 64'd1);
    check("redir_pc", redirect_pc, 64'h8000_0100);
    check("redir_csr_wen", {63'd0, csr_wen}, 64'd0);
    check("redir_stall", {63'd0, stall}, 64'd1);
    idle();
    tick();
    check("post_redir_valid", {63'd0, redirect_valid}, 64'd0);
    check("post_stall", {63'd0, stall}, 64'd0);
    check("post_priv", {62'd0, priv_mode}, 64'd3);
    check("post_minstret", minstret, exp_minstret);

    // Reset in T_CAUSE aborts the trap.
    drive(1'b1, 4'd5, 64'h8000_0040, 5'd1, 1'b1, 1'b0, 12'd0, 64'h8, 64'd0, 2'd1);
    tick();
    tick();
    check("abort_in_cause", {52'd0, csr_wa}, 64'h342);
    reset = 1'b1;
    idle();
    #1;
    check("abort_cause_wen", {63'd0, csr_wen}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("abort_stall", {63'd0, stall}, 64'd0);
    check("abort_csr_wen", {63'd0, csr_wen}, 64'd0);
    check("abort_redir", {63'd0, redirect_valid}, 64'd0);
    check("abort_redir_pc", redirect_pc, 64'd0);
    check("abort_minstret", minstret, 64'd0);
    check("abort_priv", {62'd0, priv_mode}, 64'd3);
    tick();
    check("abort_late_csr_wen", {63'd0, csr_wen}, 64'd0);
    check("abort_late_redir", {63'd0, redirect_valid}, 64'd0);

    // minstret wrap.
    force dut.minstret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.minstret_q;
    #1;
    check("wrap_preload", minstret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 4'd0, 64'h300, 5'd2, 1'b1, 1'b0, 12'd0, 64'd0, 64'h1, 2'd3);
    tick();
    check("wrap_minstret", minstret, 64'd0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: dataW  input  writeback_data_t  retiring instruction from writeback; valid when dataW.valid=1.
REQ-004 SHALL have port: mtvec  input  64  trap vector base from CSR file.
REQ-005 SHALL have ports: rf_wen/rf_wa/rf_wd  output  1/5/64  GPR write port.
REQ-006 SHALL have ports: csr_wen/csr_wa/csr_wd  output  1/12/64  CSR write port.
REQ-007 SHALL have ports: redirect_valid/redirect_pc  output  1/64  front-end redirect on trap.
REQ-008 SHALL have port: stall  output  1  freezes the whole pipeline upstream of wb_commit.
REQ-009 SHALL have ports: priv_mode  output  2  current privilege; minstret  output  64  retired-instruction count.

Function
REQ-010 SHALL implement FSM states RUN, T_EPC, T_CAUSE, T_STATUS, T_REDIR; reset state RUN.
REQ-011 In RUN with dataW.valid=1 and dataW.excep=0: SHALL assert rf_wen the same cycle iff dataW.ctl.regwrite=1 and dataW.dst!=0, rf_wa=dataW.dst, rf_wd=dataW.writedata.
REQ-012 In RUN, same condition: SHALL assert csr_wen iff dataW.ctl.csrwrite=1, csr_wa=dataW.csraddr, csr_wd=dataW.csrdata; GPR and CSR writes from one instruction occur in the same cycle.
REQ-013 minstret SHALL increment by 1 on the edge following each non-excepting valid commit; wraps 2^64-1 -> 0.
REQ-014 In RUN with dataW.valid=1 and dataW.excep!=0: SHALL suppress rf_wen/csr_wen, latch pc, excep and priviledgeMode, assert stall, go to T_EPC.
REQ-015 T_EPC SHALL write mepc (0x341) = latched pc; T_CAUSE SHALL write mcause (0x342) = zero-extended latched excep code; T_STATUS SHALL write mstatus (0x300) with MPP = latched privilege, MPIE = old MIE, MIE = 0; one state per cycle.
REQ-016 T_REDIR SHALL assert redirect_valid for exactly one cycle with redirect_pc = {mtvec[63:2],2'b00}, set priv_mode=3 (M), then return to RUN.
REQ-017 stall SHALL be 1 from the cycle the exception is seen through T_REDIR inclusive (5 cycles); 0 in RUN otherwise.
REQ-018 dataW SHALL be ignored outside RUN; upstream holds it under stall.
REQ-019 Writes with dst=0 SHALL never assert rf_wen; dataW.valid=0 SHALL produce no write and no count.
REQ-020 priv_mode SHALL follow dataW.priviledgeMode on every valid non-excepting commit in RUN.
REQ-021 mstatus old MIE SHALL be taken from dataW.csrdata latched at exception detection (csrdata carries current mstatus for excepting instructions).

Reset
REQ-022 On reset: state=RUN, stall=0, all *_wen=0, redirect_valid=0, redirect_pc=0, minstret=0, priv_mode=3, latches=0.
REQ-023 Reset asserted mid-trap SHALL abort the sequence with no further CSR writes or redirect.

Structure
REQ-024 SHALL define commit_state_t enum and CSR address constants (CSR_MSTATUS, CSR_MEPC, CSR_MCAUSE) and PRIV_M in the shared pipes/common package; ctl.regwrite/ctl.csrwrite SHALL exist in control_t.
REQ-025 Trap sequencing SHALL be a sub-module trap_seq (FSM + latches); wb_commit instantiates it and muxes write ports.

Verification
REQ-026 Valid add, dst=5, writedata=0x1234, regwrite=1 -> rf_wen=1, rf_wa=5, rf_wd=0x1234 same cycle; minstret 0->1.
REQ-027 Valid instr, dst=0, regwrite=1 -> rf_wen=0; minstret still increments.
REQ-028 csrrw: dst=3, csraddr=0x305, csrdata=0x80000000, writedata=0x7 -> rf and csr writes same cycle.
REQ-029 Exception excep=2, pc=0x80000010, priv=0, mtvec=0x80000101 -> mepc=0x80000010, mcause=2, mstatus MPP=0, then redirect_pc=0x80000100 one cycle, stall high 5 cycles, priv_mode=3, minstret unchanged.
REQ-030 Reset asserted during T_CAUSE -> next cycle state RUN, no mstatus write, no redirect, all outputs at reset values.
REQ-031 minstret preloaded via force to 0xFFFF_FFFF_FFFF_FFFF, one commit -> 0.
